fa_serial_ctrl: RTL
===================

Name: fa_serial_ctrl

Overview:
Bit-serial adder controller. Computes WIDTH-bit sums using one 1-bit full adder instance (fa_dataflow: ports s, co, a, b, ci) over WIDTH clock cycles. Provides a start/busy/done handshake. Serves as the area-minimal sequenced alternative to a ripple adder in the Practice02 adder family.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous active-high reset
start  input   1      request an addition; accepted only when busy==0
a      input   WIDTH  operand A; sampled at the accept edge only
b      input   WIDTH  operand B; sampled at the accept edge only
ci     input   1      carry-in; sampled at the accept edge only
busy   output  1      high while an addition is in progress (RUN state)
done   output  1      one-cycle pulse; s/co hold a new result
s      output  WIDTH  sum, a+b+ci mod 2^WIDTH; held until the next result
co     output  1      carry out of the MSB; held until the next result

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - busy=0, done=0, s=0, co=0.
  - Internal operand shift registers, carry flop, partial-sum register and bit counter all cleared.
  - A reset mid-RUN aborts the operation. No done pulse follows, and s/co read 0.
- States: IDLE, RUN, DONE.
  - busy = (state==RUN).
  - done = (state==DONE), registered.
- Accept rule: start is accepted on a rising edge when state is IDLE or DONE. This allows back-to-back operations with no idle gap.
  - Accept edge actions: opA<=a, opB<=b, carry<=ci, psum<=0, cnt<=0, state<=RUN.
  - start while busy is ignored; it is neither queued nor errored.
- RUN, each edge:
  - The full adder is fed opA[0], opB[0], carry.
  - psum <= {fa.s, psum[WIDTH-1:1]}; carry <= fa.co.
  - opA and opB shift right by 1 with zero fill; cnt increments.
- The edge that processes bit WIDTH-1 (cnt==WIDTH-1):
  - s <= {fa.s, psum[WIDTH-1:1]}, co <= fa.co.
  - state <= DONE.
- DONE: lasts exactly one cycle.
  - Next state is RUN if start is accepted, otherwise IDLE.
  - s/co are not modified.
- Latency: for accept edge E0, bits are processed on edges E1..E_WIDTH.
  - done is high for the cycle after E_WIDTH.
  - busy is high from after E0 until E_WIDTH.
  - Accept-to-done is WIDTH cycles.
- s/co are written only on the final RUN edge (and by reset), so they stay stable during RUN.
- Changes on a/b/ci during RUN have no effect on the result in progress.
- Arithmetic: {co,s} == a + b + ci, with a, b, ci zero-extended to WIDTH+1 bits.
- cnt width is $clog2(WIDTH). Wrap-around is not reachable because RUN exits at WIDTH-1.

Test Plan (WIDTH=8):
- Sum with carry-in: a=8'hA5, b=8'h5A, ci=1, start pulse → busy for 8 cycles, done pulse 8 cycles after accept, s=8'h00, co=1.
- Overflow: a=8'hFF, b=8'h01, ci=0 → s=8'h00, co=1. Also a=8'h7F, b=8'h01, ci=0 → s=8'h80, co=0. Also a=0, b=0, ci=0 → s=0, co=0.
- Busy protection: start held high during RUN with a changed to 8'h00 mid-run, original a=8'h10, b=8'h20 → single result s=8'h30, co=0.
  - Exactly one done is issued per accept.
  - No second operation starts until IDLE/DONE.
- Back-to-back: start asserted in the DONE cycle with a=8'h01, b=8'h01, ci=1, after a first op 8'hF0+8'h0F → first result s=8'hFF, co=0.
  - busy rises the cycle after done.
  - Second done arrives 8 cycles later with s=8'h03, co=0.
- Reset mid-operation: rst pulsed 4 cycles into RUN → busy, done, s, co all go 0 immediately (asynchronously).
  - No done pulse follows.
  - A subsequent start with a=8'h33, b=8'h44, ci=0 yields s=8'h77, co=0.
- Exhaustive check: sweep all a, b ∈ {0..255} and ci ∈ {0,1} → {co,s} == a+b+ci for every op.
  - done occurs exactly 8 cycles after each accept.

Source files
------------

// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder controller: one 1-bit full adder sequenced over WIDTH
// clock cycles, LSB first, with a start/busy/done handshake.

// 1-bit full adder, pure dataflow.
module fa_dataflow (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module fa_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] opa_q, opb_q;
  logic             carry_q;
  logic [WIDTH-1:0] psum_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;

  logic fa_s, fa_co;
  logic accept;
  logic last_bit;

  // A new op may start from IDLE or straight out of DONE (no idle gap).
  assign accept   = start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  fa_dataflow u_fa (
    .s  (fa_s),
    .co (fa_co),
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start during RUN is simply ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the registered state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Serial datapath: operands shift out LSB first, sum bits shift in at the
  // MSB so after WIDTH steps psum holds the result in natural order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      opa_q   <= a;
      opb_q   <= b;
      carry_q <= ci;
      psum_q  <= '0;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      opa_q   <= opa_q >> 1;
      opb_q   <= opb_q >> 1;
      carry_q <= fa_co;
      psum_q  <= {fa_s, psum_q[WIDTH-1:1]};
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Result registers load only on the final bit so s/co stay stable
  // through RUN and DONE until the next result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else if (last_bit) begin
      s_q  <= {fa_s, psum_q[WIDTH-1:1]};
      co_q <= fa_co;
    end
  end

  assign s  = s_q;
  assign co = co_q;
endmodule
